// File: rtl/hilo_pkg.sv
// ============================================================================
// Module : hilo_pkg
// Brief  : Shared op encodings, FSM state type and width default for the
//          HI/LO multiply/divide unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hilo_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter_core.sv
// ============================================================================
// Module : muldiv_iter_core
// Brief  : Unsigned one-bit-per-cycle shift-add multiplier / restoring divider.
//          {acc_hi,acc_lo} ends as the product, or remainder/quotient.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_iter_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              div_mode,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  logic              step,
  output logic [DATA_W-1:0] acc_hi,
  output logic [DATA_W-1:0] acc_lo,
  output logic              last
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_b;
  logic              r_div;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_shl;
  logic [DATA_W:0]   w_trial;
  logic [DATA_W-1:0] w_hi_nxt;
  logic [DATA_W-1:0] w_lo_nxt;

  // Divide: the partial remainder stays below the divisor, so bit DATA_W of
  // the trial difference is a clean borrow flag (also holds for divisor 0).
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shl   = {r_hi, r_lo[DATA_W-1]};
    w_trial = w_shl - {1'b0, r_b};
    if (r_div) begin
      if (!w_trial[DATA_W]) begin
        w_hi_nxt = w_trial[DATA_W-1:0];
        w_lo_nxt = {r_lo[DATA_W-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_shl[DATA_W-1:0];
        w_lo_nxt = {r_lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      w_hi_nxt = w_sum[DATA_W:1];
      w_lo_nxt = {w_sum[0], r_lo[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_div <= 1'b0;
      r_cnt <= '0;
    end else if (load) begin
      r_hi  <= '0;
      r_lo  <= opa;
      r_b   <= opb;
      r_div <= div_mode;
      r_cnt <= '0;
    end else if (step) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign acc_hi = r_hi;
  assign acc_lo = r_lo;
  assign last   = step && (r_cnt == CNT_W'(DATA_W - 1));

endmodule

`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
// ============================================================================
// Module : hilo_muldiv_unit
// Brief  : HI/LO register producer: iterative MULT/MULTU/DIV/DIVU, MTHI/MTLO.
//          Optional macro HILO_BYPASS_EN forwards MTHI/MTLO data same cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_done;
  logic              r_op_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_div_zero;
  logic [DATA_W-1:0] r_a_raw;

  logic              w_start_ok;
  logic              w_mthi;
  logic              w_mtlo;
  logic              w_load;
  logic              w_step;
  logic              w_fix;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_abs_a;
  logic [DATA_W-1:0] w_abs_b;

  logic [DATA_W-1:0] w_core_hi;
  logic [DATA_W-1:0] w_core_lo;
  logic              w_core_last;

  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_res_hi;
  logic [DATA_W-1:0]   w_res_lo;

  assign w_start_ok = start && (r_state == ST_IDLE);
  assign w_mthi     = w_start_ok && (op == OP_MTHI);
  assign w_mtlo     = w_start_ok && (op == OP_MTLO);
  assign w_a_neg    = op_is_signed(op) && A[DATA_W-1];
  assign w_b_neg    = op_is_signed(op) && B[DATA_W-1];
  assign w_abs_a    = w_a_neg ? -A : A;
  assign w_abs_b    = w_b_neg ? -B : B;

  muldiv_iter_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk      (clk),
    .rst      (reset),
    .load     (w_load),
    .div_mode (op[1]),
    .opa      (w_abs_a),
    .opb      (w_abs_b),
    .step     (w_step),
    .acc_hi   (w_core_hi),
    .acc_lo   (w_core_lo),
    .last     (w_core_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok && !op[2]) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (w_core_last) begin
          w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sign restoration; a zero divisor bypasses it so HI returns the raw dividend.
  always_comb begin
    w_prod = {w_core_hi, w_core_lo};
    if (r_neg_q) begin
      w_prod = -w_prod;
    end
    w_quo = r_neg_q ? -w_core_lo : w_core_lo;
    w_rem = r_neg_r ? -w_core_hi : w_core_hi;
    if (!r_op_div) begin
      w_res_hi = w_prod[2*DATA_W-1:DATA_W];
      w_res_lo = w_prod[DATA_W-1:0];
    end else if (r_div_zero) begin
      w_res_hi = r_a_raw;
      w_res_lo = '1;
    end else begin
      w_res_hi = w_rem;
      w_res_lo = w_quo;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_op_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_a_raw    <= '0;
    end else begin
      r_done <= w_fix;
      if (w_load) begin
        r_op_div   <= op[1];
        r_neg_q    <= w_a_neg ^ w_b_neg;
        r_neg_r    <= w_a_neg;
        r_div_zero <= op[1] && (B == '0);
        r_a_raw    <= A;
      end
      if (w_fix) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else begin
        if (w_mthi) r_hi <= A;
        if (w_mtlo) r_lo <= A;
      end
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;

`ifdef HILO_BYPASS_EN
  assign HI = w_mthi ? A : r_hi;
  assign LO = w_mtlo ? A : r_lo;
`else
  assign HI = r_hi;
  assign LO = r_lo;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
// ============================================================================
// Module : tb_hilo_muldiv_unit
// Brief  : Directed self-checking bench for hilo_muldiv_unit (DATA_W=32).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_pass  = 0;
  int n_total = 0;

  hilo_muldiv_unit #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts remaining busy cycles, then checks the result at the done cycle.
  task automatic wait_done(input string tag, input int exp_cyc,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int          cyc;
    logic        hold_ok;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    cyc     = 0;
    hold_ok = 1'b1;
    prev_hi = HI;
    prev_lo = LO;
    while (busy && cyc < 100) begin
      cyc++;
      if (HI !== prev_hi || LO !== prev_lo || done !== 1'b0) hold_ok = 1'b0;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " hold"}, 32'(hold_ok), 32'd1);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " HI"}, HI, exp_hi);
    check({tag, " LO"}, LO, exp_lo);
  endtask

  initial begin
    int n_done;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    check("rst HI", HI, 32'h0);
    check("rst LO", LO, 32'h0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 33, 32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);
    check("multu_max done_clear", 32'(done), 32'd0);

    issue(OP_MULT, 32'hFFFF_FFF9, 32'd6);
    wait_done("mult_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
    // back-to-back start in the done cycle
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done("divu", 33, 32'd2, 32'd14);
    issue(OP_DIVU, 32'h0000_1234, 32'd0);
    wait_done("divu_zero", 33, 32'h0000_1234, 32'hFFFF_FFFF);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 33, 32'h0, 32'h8000_0000);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done("div_zero_neg", 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_minmin", 33, 32'h4000_0000, 32'h0);
    @(negedge clk);

    start = 1'b1; op = OP_MTHI; A = 32'hDEAD_BEEF;
    #1;
`ifdef HILO_BYPASS_EN
    check("mthi same_cycle", HI, 32'hDEAD_BEEF);
`else
    check("mthi same_cycle", HI, 32'h4000_0000);
`endif
    @(negedge clk);
    start = 1'b0;
    check("mthi HI", HI, 32'hDEAD_BEEF);
    check("mthi LO", LO, 32'h0);
    check("mthi done", 32'(done), 32'd0);
    check("mthi busy", 32'(busy), 32'd0);

    start = 1'b1; op = OP_MTLO; A = 32'h0BAD_F00D;
    #1;
`ifdef HILO_BYPASS_EN
    check("mtlo same_cycle", LO, 32'h0BAD_F00D);
`else
    check("mtlo same_cycle", LO, 32'h0);
`endif
    @(negedge clk);
    start = 1'b0;
    check("mtlo LO", LO, 32'h0BAD_F00D);
    check("mtlo HI", HI, 32'hDEAD_BEEF);
    check("mtlo done", 32'(done), 32'd0);

    issue(OP_MULTU, 32'd2, 32'd3);
    repeat (3) @(negedge clk);
    start = 1'b1; op = OP_MTLO; A = 32'h5555_5555;
    #1;
    check("mtlo_busy same_cycle", LO, 32'h0BAD_F00D);
    @(negedge clk);
    start = 1'b0;
    check("mtlo_busy LO", LO, 32'h0BAD_F00D);
    wait_done("multu_small", 29, 32'h0, 32'd6);
    @(negedge clk);

    issue(OP_MULT, 32'h1234_5678, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst HI", HI, 32'h0);
    check("midrst LO", LO, 32'h0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrst no_done", 32'(n_done), 32'd0);
    check("midrst LO_after", LO, 32'h0);

    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_done("multu_after_rst", 33, 32'h1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
